fwd_scoreboard: RTL
===================

# fwd_scoreboard

Parametrised operand bypass and hazard controller for the EXE stage. For each of `NUM_SRC` source operands it picks the youngest of `NUM_FWD` in-flight producer stages, or the register file. A small scoreboard tracks long-latency writes (divider, multiplier) and raises `stall` on load-use and long-latency RAW hazards. It sits between the ID/EXE pipeline register and the EXE operand muxes, and its `stall` feeds the pipeline hazard/freeze logic.

## Interface
Parameters:
- `NUM_SRC`, 2: source operands checked per cycle.
- `NUM_FWD`, 2: bypass stages. Stage 1 is nearest (MEM), stage `NUM_FWD` is oldest (WB).
- `SB_DEPTH`, 4: scoreboard entries for long-latency writes.
- `MAX_LAT`, 8: maximum latency accepted on the issue port.

Ports. Reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `src_reg`  in  `NUM_SRC*5`  source register numbers; operand i is in bits [5i+4:5i].
- `src_used`  in  `NUM_SRC`  operand i is actually read.
- `stg_wr`  in  `NUM_FWD`  stage k writes the register file.
- `stg_dst`  in  `NUM_FWD*5`  destination register per stage.
- `stg_data_ok`  in  `NUM_FWD`  stage k result is available this cycle; 0 for a load still in MEM.
- `issue_valid`  in  1  long-latency op issues this cycle.
- `issue_ready`  out  1  scoreboard can accept an issue.
- `issue_dst`  in  5  destination of the long-latency op.
- `issue_lat`  in  `$clog2(MAX_LAT+1)`  cycles until its result appears on a bypass stage.
- `flush`  in  1  discard all pending scoreboard entries.
- `fwd_sel`  out  `NUM_SRC*SEL_W`  per-operand select: 0 = register file, k = stage k. `SEL_W = $clog2(NUM_FWD+1)`.
- `stall`  out  1  EXE must hold.
- `sb_busy`  out  1  at least one scoreboard entry is valid.
- `stall_cnt`  out  32  stall-cycle counter (see Configuration).

## Operation
Forward selection (combinational):
- Operand i matches stage k when `stg_wr[k]`, `stg_dst[k] != 0` and `stg_dst[k] == src_reg[i]`.
- `fwd_sel[i]` is the lowest matching k (youngest producer wins). It is 0 if there is no match, `src_reg[i] == 0`, or `!src_used[i]`.

Load-use hazard:
- `stall` asserts if any used operand's selected stage k has `stg_data_ok[k] == 0`.

Scoreboard:
- `SB_DEPTH` entries, each holding {valid, dst[4:0], cnt}.
- `issue_ready = 1` when any entry is free. Free slots are computed from `valid` at the start of the cycle, so a slot expiring this cycle is not reused in the same cycle.
- Accept when `issue_valid && issue_ready`:
  - The lowest-index free entry loads {1, `issue_dst`, `issue_lat`}.
  - `issue_lat == 0` is treated as 1; `issue_lat > MAX_LAT` is clamped to `MAX_LAT`.
  - `issue_dst == 0` is accepted but allocates no entry.
- `issue_valid` with `issue_ready == 0` is ignored; the issuer must hold the request.
- Every valid entry decrements `cnt` each cycle, regardless of `stall`. When `cnt == 1`, the entry clears on the next edge.
- Long-latency RAW: `stall` also asserts if any valid entry's dst equals a used, nonzero `src_reg[i]`.
- WAW: duplicate dsts may coexist; the stall holds until all matching entries clear.
- `flush` clears every entry on the next edge. It has priority over a same-cycle issue, and the issue is dropped.
- `sb_busy = |valid`.

## Timing
- `fwd_sel` and `stall` are combinational from inputs and registered scoreboard state; there is no added latency.
- An issue accepted at edge T is visible from T+1. With latency L it stalls a matching consumer during cycles T+1..T+L; `stall` falls in cycle T+L+1, when the result must be on a bypass stage.
- Reset values: all entries invalid, `issue_ready = 1`, `sb_busy = 0`, `stall = 0` (given quiescent inputs), `stall_cnt = 0`.
- Reset mid-operation discards all entries on the same edge.

## Configuration
- `FWD_STALL_CNT_EN` defined:
  - `stall_cnt` increments on every cycle with `stall == 1` and is not cleared by `flush`.
  - The counter saturates at `32'hFFFF_FFFF` and clears only on `rst`.
- `FWD_STALL_CNT_EN` undefined: `stall_cnt` is tied to 0 and no counter register exists.

## Structure
- Shared package `fwd_pkg` holds:
  - `SEL_W` and `LAT_W` localparam functions;
  - `fwd_sel_t`;
  - `sb_entry_t` struct {valid, dst, cnt};
  - the `FWD_SEL_RF = 0` constant.
- Sub-module `fwd_prio_sel`: one per operand, generated `NUM_SRC` times. It takes one `src_reg`/`src_used` plus all stage inputs and outputs `fwd_sel` and a per-operand `not_ok` hazard bit.

## Test plan
- Producer of reg 8 in both stages (`stg_wr = 2'b11`, `stg_dst = {8,8}`), `src_reg[0] = 8` -> `fwd_sel[0] = 1`, `stall = 0`.
- `src_reg[1] = 0` with a stage writing reg 0 -> `fwd_sel[1] = 0`. `src_used[0] = 0` with a matching stage -> `fwd_sel[0] = 0`.
- Load in stage 1 (dst 5, `stg_data_ok[0] = 0`), `src_reg[0] = 5` -> `stall = 1`. Next cycle the producer moves to stage 2 with ok = 1 -> `fwd_sel[0] = 2`, `stall = 0`.
- Issue dst 9, lat 4 at edge T, consumer reads reg 9 -> `stall = 1` for cycles T+1..T+4 and 0 at T+5; `sb_busy` follows the same window.
- Four issues fill the scoreboard -> `issue_ready = 0` and a fifth `issue_valid` is ignored. When one entry expires, `issue_ready` returns to 1 the cycle after.
- `flush` with 3 valid entries plus a same-cycle issue -> next cycle `sb_busy = 0` and the issue is dropped. With `FWD_STALL_CNT_EN`, `stall_cnt` equals the number of stalled cycles counted so far.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and helpers for the EXE-stage operand bypass and
// hazard controller (fwd_scoreboard and fwd_prio_sel).
//   sel_w(num_fwd) : width of a per-operand forward select (0 = register file)
//   lat_w(max_lat) : width of the long-latency issue latency field
//   fwd_sel_t      : forward select for the default two-stage bypass
//   sb_entry_t     : one scoreboard entry {valid, dst, cnt}
//   FWD_SEL_RF     : select value meaning "read the register file"
package fwd_pkg;

    localparam int FWD_SEL_RF  = 0;
    // Scoreboard countdown width; fixed so the entry struct is shareable.
    // Holds any MAX_LAT up to 255.
    localparam int SB_CNT_W    = 8;
    localparam int DEF_NUM_FWD = 2;

    function automatic int sel_w(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

    function automatic int lat_w(input int max_lat);
        return $clog2(max_lat + 1);
    endfunction

    typedef logic [sel_w(DEF_NUM_FWD)-1:0] fwd_sel_t;

    typedef struct packed {
        logic                valid;
        logic [4:0]          dst;
        logic [SB_CNT_W-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/fwd_scoreboard_prio_sel.sv
// fwd_prio_sel: bypass priority selector for one source operand.
// Picks the youngest (lowest-numbered) bypass stage writing the operand's
// register and flags a load-use hazard when that stage has no data yet.
//   i_src_reg      source register number
//   i_src_used     operand is actually read
//   i_stg_wr       per-stage register-file write enable
//   i_stg_dst      per-stage destination register (5 bits each)
//   i_stg_data_ok  per-stage result available this cycle
//   o_fwd_sel      0 = register file, k = stage k
//   o_not_ok       selected stage cannot supply data this cycle
module fwd_prio_sel
    import fwd_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = sel_w(NUM_FWD)
) (
    input  logic [4:0]           i_src_reg,
    input  logic                 i_src_used,
    input  logic [NUM_FWD-1:0]   i_stg_wr,
    input  logic [NUM_FWD*5-1:0] i_stg_dst,
    input  logic [NUM_FWD-1:0]   i_stg_data_ok,
    output logic [SEL_W-1:0]     o_fwd_sel,
    output logic                 o_not_ok
);

    always_comb begin
        // NOTE: outputs take a default before any branch so no path leaves
        // them unassigned; this is what keeps the block free of latches.
        o_fwd_sel = SEL_W'(FWD_SEL_RF);
        o_not_ok  = 1'b0;
        // r0 is never forwarded; a nonzero source also rules out a dst of 0.
        if (i_src_used && (i_src_reg != 5'd0)) begin
            // Scan oldest to youngest so a younger match overrides an older one.
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (i_stg_wr[k] && (i_stg_dst[5*k +: 5] == i_src_reg)) begin
                    o_fwd_sel = SEL_W'(k + 1);
                    o_not_ok  = !i_stg_data_ok[k];
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand bypass select and hazard controller for EXE.
// Forwards each source operand from the youngest in-flight producer and
// tracks long-latency writes in a small countdown scoreboard; stall covers
// load-use and long-latency RAW hazards.
// Optional feature macro: FWD_STALL_CNT_EN (saturating stall-cycle counter).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   src_reg, src_used         source operands (5 bits each) and read flags
//   stg_wr, stg_dst           bypass stage write enables / destinations
//   stg_data_ok               stage result available this cycle
//   issue_valid/_ready        long-latency issue handshake
//   issue_dst, issue_lat      long-latency destination and latency
//   flush                     drop all pending scoreboard entries
//   fwd_sel                   per-operand select (0 = register file)
//   stall                     EXE must hold
//   sb_busy                   any scoreboard entry valid
//   stall_cnt                 stall-cycle counter (0 unless enabled)
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 2,
    parameter int SB_DEPTH = 4,
    parameter int MAX_LAT  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_SRC*5-1:0]               src_reg,
    input  logic [NUM_SRC-1:0]                 src_used,
    input  logic [NUM_FWD-1:0]                 stg_wr,
    input  logic [NUM_FWD*5-1:0]               stg_dst,
    input  logic [NUM_FWD-1:0]                 stg_data_ok,
    input  logic                               issue_valid,
    output logic                               issue_ready,
    input  logic [4:0]                         issue_dst,
    input  logic [lat_w(MAX_LAT)-1:0]          issue_lat,
    input  logic                               flush,
    output logic [NUM_SRC*sel_w(NUM_FWD)-1:0]  fwd_sel,
    output logic                               stall,
    output logic                               sb_busy,
    output logic [31:0]                        stall_cnt
);

    localparam int SEL_W = sel_w(NUM_FWD);
    localparam int LAT_W = lat_w(MAX_LAT);

    sb_entry_t             r_sb [SB_DEPTH];
    logic [NUM_SRC-1:0]    w_not_ok;
    logic [SB_DEPTH-1:0]   w_valid;
    logic [SB_DEPTH-1:0]   w_alloc_oh;
    logic [SB_CNT_W-1:0]   w_issue_cnt;
    logic                  w_accept;
    logic                  w_raw;

    // Forward selection, one priority selector per operand.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_prio_sel #(
            .NUM_FWD (NUM_FWD),
            .SEL_W   (SEL_W)
        ) u_sel (
            .i_src_reg     (src_reg[5*g +: 5]),
            .i_src_used    (src_used[g]),
            .i_stg_wr      (stg_wr),
            .i_stg_dst     (stg_dst),
            .i_stg_data_ok (stg_data_ok),
            .o_fwd_sel     (fwd_sel[SEL_W*g +: SEL_W]),
            .o_not_ok      (w_not_ok[g])
        );
    end

    for (genvar e = 0; e < SB_DEPTH; e++) begin : g_valid
        assign w_valid[e] = r_sb[e].valid;
    end

    // Free slots come from registered valids only, so an entry expiring
    // this cycle is not handed out again until the following cycle.
    assign issue_ready = ~&w_valid;
    assign sb_busy     = |w_valid;

    always_comb begin
        logic found;
        found      = 1'b0;
        w_alloc_oh = '0;
        for (int e = 0; e < SB_DEPTH; e++) begin
            if (!w_valid[e] && !found) begin
                w_alloc_oh[e] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    // A latency of 0 would never be seen by a consumer; treat it as 1.
    always_comb begin
        if (issue_lat == '0)
            w_issue_cnt = SB_CNT_W'(1);
        else if (issue_lat > LAT_W'(MAX_LAT))
            w_issue_cnt = SB_CNT_W'(MAX_LAT);
        else
            w_issue_cnt = SB_CNT_W'(issue_lat);
    end

    // Writes to r0 are accepted but need no tracking; flush drops the issue.
    assign w_accept = issue_valid && issue_ready && !flush && (issue_dst != 5'd0);

    always_ff @(posedge clk) begin
        for (int e = 0; e < SB_DEPTH; e++) begin
            // NOTE: only the valid bits are reset; dst and cnt are ignored
            // while an entry is invalid and are rewritten on allocation.
            if (rst || flush) begin
                // NOTE: non-blocking assignments so every entry updates from
                // the same pre-edge state regardless of loop order.
                r_sb[e].valid <= 1'b0;
            end else if (w_accept && w_alloc_oh[e]) begin
                r_sb[e] <= '{valid: 1'b1, dst: issue_dst, cnt: w_issue_cnt};
            end else if (r_sb[e].valid) begin
                r_sb[e].cnt <= r_sb[e].cnt - SB_CNT_W'(1);
                if (r_sb[e].cnt == SB_CNT_W'(1))
                    r_sb[e].valid <= 1'b0;
            end
        end
    end

    // Long-latency RAW: any valid entry (duplicates included) targeting a
    // used nonzero source holds EXE until every such entry has expired.
    always_comb begin
        w_raw = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int e = 0; e < SB_DEPTH; e++) begin
                if (src_used[i] && (src_reg[5*i +: 5] != 5'd0) &&
                    r_sb[e].valid && (r_sb[e].dst == src_reg[5*i +: 5]))
                    w_raw = 1'b1;
            end
        end
    end

    assign stall = w_raw || (|w_not_ok);

`ifdef FWD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Survives flush; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (stall && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
